// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Hazard / control unit for a 5-stage RISC-V pipeline. Drives the
//             pipeline-register stall, bubble and flush controls, PC redirect,
//             EX operand forwarding selects and saturating perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_valid,
   input  logic [4:0]       id_ex_rs1,
   input  logic [4:0]       id_ex_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_memRead,
   input  logic             id_ex_valid,
   input  logic             ex_branch_taken,
   input  logic [4:0]       ex_mem_rd,
   input  logic             ex_mem_we,
   input  logic             ex_mem_valid,
   input  logic [4:0]       mem_wb_rd,
   input  logic             mem_wb_we,
   input  logic             mem_wb_valid,
   input  logic             imem_busywait,
   input  logic             dmem_busywait,
   output logic             stall_pc,
   output logic             stall_if_id,
   output logic             stall_id_ex,
   output logic             stall_ex_mem,
   output logic             flush_if_id,
   output logic             bubble_id_ex,
   output logic             pc_redirect,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             pend_br_q, pend_br_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   logic ex_mem_fwd_ok;
   logic mem_wb_fwd_ok;
   logic load_use;
   logic flush_applied;

   // Producer stages that may legally forward (never x0).
   assign ex_mem_fwd_ok = ex_mem_valid & ex_mem_we & (ex_mem_rd != 5'd0);
   assign mem_wb_fwd_ok = mem_wb_valid & mem_wb_we & (mem_wb_rd != 5'd0);

   // Load in EX whose destination is read by the instruction in ID.
   assign load_use = id_valid & id_ex_valid & id_ex_memRead & (id_ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == id_ex_rd)) |
                      (id_use_rs2 & (id_rs2 == id_ex_rd)));

   // Forwarding selects, EX/MEM has priority over MEM/WB; forced off in reset.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!reset) begin
         if (ex_mem_fwd_ok && (ex_mem_rd == id_ex_rs1))      fwd_a = 2'b01;
         else if (mem_wb_fwd_ok && (mem_wb_rd == id_ex_rs1)) fwd_a = 2'b10;
         if (ex_mem_fwd_ok && (ex_mem_rd == id_ex_rs2))      fwd_b = 2'b01;
         else if (mem_wb_fwd_ok && (mem_wb_rd == id_ex_rs2)) fwd_b = 2'b10;
      end
   end

   // Next-state and hazard control outputs, highest priority first.
   always_comb begin
      state_d       = state_q;
      pend_br_d     = pend_br_q;
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      stall_id_ex   = 1'b0;
      stall_ex_mem  = 1'b0;
      flush_if_id   = 1'b0;
      bubble_id_ex  = 1'b0;
      pc_redirect   = 1'b0;
      flush_applied = 1'b0;
      if (reset) begin
         flush_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
         state_d      = RUN;
         pend_br_d    = 1'b0;
      end else if (dmem_busywait) begin
         // Freeze the whole pipe; remember a branch seen while frozen.
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         stall_id_ex  = 1'b1;
         stall_ex_mem = 1'b1;
         state_d      = MEM_WAIT;
         pend_br_d    = pend_br_q | ex_branch_taken;
      end else if (state_q == FLUSH) begin
         flush_if_id   = 1'b1;
         bubble_id_ex  = 1'b1;
         pc_redirect   = 1'b1;
         flush_applied = 1'b1;
         pend_br_d     = 1'b0;
         state_d       = RUN;
      end else if ((state_q == MEM_WAIT) && (pend_br_q || ex_branch_taken)) begin
         // The deferred flush is applied from the FLUSH state next cycle.
         state_d = FLUSH;
      end else begin
         // RUN rules (also reached directly from MEM_WAIT without a branch).
         state_d = RUN;
         if (ex_branch_taken) begin
            flush_if_id   = 1'b1;
            bubble_id_ex  = 1'b1;
            pc_redirect   = 1'b1;
            flush_applied = 1'b1;
         end else if (load_use || imem_busywait) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
         end
      end
   end

   // Saturating performance counter next values.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (reset) begin
         stall_cycles_d = '0;
         flush_events_d = '0;
      end else begin
         if (stall_pc && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
         if (flush_applied && !(&flush_events_q))
            flush_events_d = flush_events_q + CNT_W'(1);
      end
   end

   // State, pending-branch flag and counter registers.
   always_ff @(posedge clock) begin
      state_q        <= state_d;
      pend_br_q      <= pend_br_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule
`default_nettype wire
